bo_bias_argmax: RTL and testbench

- Output-layer post-processor of the FNN datapath; consumes the 10 output-layer bias constants on a flat bus.
- Accepts the 10 raw output-neuron accumulator values one per handshake.
- Adds the matching sign-magnitude bias to each value, emits each biased logit, and tracks the running maximum.
- After the last neuron, reports the winning class index with a one-cycle done pulse.

---
 rtl/bo_bias_argmax.sv | 188 ++++++++++++++++++
 tb/tb_bo_bias_argmax.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bo_bias_argmax.sv
`default_nettype none
// ============================================================================
// Module   : bo_bias_argmax
// Purpose  : Output-layer post-processor for the FNN datapath. It accepts
//            N_OUT raw accumulator values, one per handshake, and adds the
//            matching sign-magnitude bias to each. Every biased logit is
//            emitted with its index. A running maximum is kept, and the
//            winning class index is reported with a one-cycle done pulse.
// Options  : BO_SAT_EN - when defined, biased sums clamp to the ACC_W signed
//            range on overflow. When undefined, they wrap (low ACC_W bits kept).
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            start      begin one pass (sampled only in IDLE)
//            bias_bus   N_OUT bias bytes, bias k at [8k+7:8k], bit7 = sign
//            acc_in     signed accumulator value for the current neuron
//            acc_valid  acc_in valid
//            acc_ready  block accepts acc_in (high in RUN)
//            out_val    biased logit
//            out_idx    neuron index of out_val
//            out_valid  one-cycle strobe qualifying out_val/out_idx
//            class_idx  argmax result, held until the next pass completes
//            done       one-cycle pulse, class_idx is final
//            busy       high in RUN and DONE
// Revision : 1.0 - initial release
// ============================================================================
module bo_bias_argmax #(
    parameter int N_OUT      = 10,
    parameter int ACC_W      = 16,
    parameter int BIAS_SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [8*N_OUT-1:0]   bias_bus,
    input  logic [ACC_W-1:0]     acc_in,
    input  logic                 acc_valid,
    output logic                 acc_ready,
    output logic [ACC_W-1:0]     out_val,
    output logic [3:0]           out_idx,
    output logic                 out_valid,
    output logic [3:0]           class_idx,
    output logic                 done,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_last = 4'(N_OUT - 1);

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [ACC_W-1:0]   r_max_val;
    logic [3:0]         r_max_idx;
    logic               r_acc_ready;
    logic [ACC_W-1:0]   r_out_val;
    logic [3:0]         r_out_idx;
    logic               r_out_valid;
    logic [3:0]         r_class_idx;
    logic               r_done;
    logic               r_busy;

    logic [7:0]         w_bias_byte;
    logic [ACC_W-1:0]   w_mag;
    logic [ACC_W-1:0]   w_bias;
    logic [ACC_W-1:0]   w_sum;
    logic               w_accept;
    logic               w_take;
    logic [3:0]         w_new_max_idx;

    // Select the bias byte for the neuron currently being accepted.
    always_comb begin
        w_bias_byte = 8'd0;
        for (int k = 0; k < N_OUT; k++) begin
            if (r_cnt == 4'(k)) begin
                w_bias_byte = bias_bus[8*k +: 8];
            end
        end
    end

    // Sign-magnitude decode. The shifted magnitude always fits in ACC_W bits
    // for sane parameter choices, so ACC_W-bit two's complement is exact.
    // Negative zero naturally becomes 0 because -0 == 0.
    assign w_mag  = ACC_W'(w_bias_byte[6:0]) << BIAS_SHIFT;
    assign w_bias = w_bias_byte[7] ? (-w_mag) : w_mag;

`ifdef BO_SAT_EN
    localparam logic [ACC_W-1:0] c_sat_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_sat_min = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] w_sum_wide;

    assign w_sum_wide = {acc_in[ACC_W-1], acc_in} + {w_bias[ACC_W-1], w_bias};

    // Overflow shows up as disagreement between the two top bits of the
    // widened sum. The true sign is the widest bit.
    always_comb begin
        w_sum = w_sum_wide[ACC_W-1:0];
        if (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]) begin
            w_sum = w_sum_wide[ACC_W] ? c_sat_min : c_sat_max;
        end
    end
`else
    // Wrapping sum: keeping the low ACC_W bits is a plain ACC_W-bit add.
    assign w_sum = acc_in + w_bias;
`endif

    assign w_accept = acc_valid & r_acc_ready;

    // First neuron loads the maximum unconditionally. Later neurons replace it
    // only when strictly greater, so ties keep the lowest index.
    assign w_take        = (r_cnt == 4'd0) || ($signed(w_sum) > $signed(r_max_val));
    assign w_new_max_idx = w_take ? r_cnt : r_max_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_max_val   <= '0;
            r_max_idx   <= 4'd0;
            r_acc_ready <= 1'b0;
            r_out_val   <= '0;
            r_out_idx   <= 4'd0;
            r_out_valid <= 1'b0;
            r_class_idx <= 4'd0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_cnt       <= 4'd0;
                        r_acc_ready <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_out_val   <= w_sum;
                        r_out_idx   <= r_cnt;
                        r_out_valid <= 1'b1;
                        if (w_take) begin
                            r_max_val <= w_sum;
                            r_max_idx <= r_cnt;
                        end
                        if (r_cnt == c_last) begin
                            // Final neuron: the result is published on the
                            // same edge as the last logit, so done lines up
                            // with the final out_valid strobe.
                            r_class_idx <= w_new_max_idx;
                            r_acc_ready <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_cnt   <= 4'd0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_acc_ready <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign acc_ready = r_acc_ready;
    assign out_val   = r_out_val;
    assign out_idx   = r_out_idx;
    assign out_valid = r_out_valid;
    assign class_idx = r_class_idx;
    assign done      = r_done;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bo_bias_argmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_bo_bias_argmax
// Purpose  : Self-checking bench for bo_bias_argmax. Directed passes use
//            literal expected values. Randomized passes are checked against
//            an arithmetic reference model: bias decode, signed add, wrap or
//            clamp, and a strict-greater argmax.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bo_bias_argmax;

    localparam int N_OUT      = 10;
    localparam int ACC_W      = 16;
    localparam int BIAS_SHIFT = 0;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [8*N_OUT-1:0]   bias_bus;
    logic [ACC_W-1:0]     acc_in;
    logic                 acc_valid;
    logic                 acc_ready;
    logic [ACC_W-1:0]     out_val;
    logic [3:0]           out_idx;
    logic                 out_valid;
    logic [3:0]           class_idx;
    logic                 done;
    logic                 busy;

    int checks   = 0;
    int failures = 0;

    bo_bias_argmax #(
        .N_OUT      (N_OUT),
        .ACC_W      (ACC_W),
        .BIAS_SHIFT (BIAS_SHIFT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bias_bus  (bias_bus),
        .acc_in    (acc_in),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .out_val   (out_val),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .class_idx (class_idx),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Output monitor: records every strobe and every done pulse.
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] obs_val [256];
    int                      obs_idx [256];
    int n_obs        = 0;
    int n_done       = 0;
    int n_aligned    = 0;
    int done_class   = -1;

    always @(negedge clk) begin
        if (out_valid) begin
            obs_val[n_obs % 256] <= out_val;
            obs_idx[n_obs % 256] <= int'(out_idx);
            n_obs                <= n_obs + 1;
        end
        if (done) begin
            n_done     <= n_done + 1;
            done_class <= int'(class_idx);
            if (out_valid && out_idx == 4'(N_OUT - 1))
                n_aligned <= n_aligned + 1;
        end
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int model_logit(input logic [7:0] b, input int acc);
        int mag, bv, s, lo, hi;
        mag = int'(b[6:0]) << BIAS_SHIFT;
        bv  = b[7] ? -mag : mag;
        s   = acc + bv;
        lo  = -(1 << (ACC_W - 1));
        hi  = (1 << (ACC_W - 1)) - 1;
`ifdef BO_SAT_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`else
        s = ((s - lo) & ((1 << ACC_W) - 1)) + lo;
`endif
        return s;
    endfunction

    function automatic int model_argmax(input int v[N_OUT]);
        int best;
        best = 0;
        for (int i = 1; i < N_OUT; i++)
            if (v[i] > v[best]) best = i;
        return best;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (drive only, no checking)
    // ------------------------------------------------------------------
    task automatic drive_pass(input logic [8*N_OUT-1:0] bias, input int accs[N_OUT],
                              input int n_acc, input int gap_min, input int gap_max,
                              input bit start_in_gap, output bit ok);
        int  gaps;
        int  guard;
        bit  rdy;
        ok       = 1'b1;
        bias_bus = bias;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < n_acc; i++) begin
            gaps = (gap_max > 0) ? int'($urandom_range(gap_max, gap_min)) : 0;
            for (int g = 0; g < gaps; g++) begin
                acc_valid = 1'b0;
                acc_in    = ACC_W'($urandom);
                if (start_in_gap && g == 0) start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
            acc_valid = 1'b1;
            acc_in    = ACC_W'(accs[i]);
            guard     = 0;
            do begin
                @(negedge clk); rdy = acc_ready;
                @(posedge clk); #1;
                guard++;
            end while (!rdy && guard < 50);
            if (!rdy) ok = 1'b0;
        end
        acc_valid = 1'b0;
    endtask

    task automatic wait_done(input int base_done, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            if (n_done > base_done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [8*N_OUT-1:0] rand_bias();
        logic [8*N_OUT-1:0] b;
        for (int k = 0; k < N_OUT; k++) b[8*k +: 8] = 8'($urandom);
        return b;
    endfunction

    function automatic int rand_acc();
        logic [ACC_W-1:0] r;
        r = ACC_W'($urandom);
        if ($urandom_range(3, 0) != 0) r = ACC_W'($signed(r) >>> 8);
        return int'($signed(r));
    endfunction

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        acc_valid = 1'b1;
        acc_in    = 16'h1234;
        bias_bus  = '0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({acc_ready, out_valid, done, busy, out_val, out_idx, class_idx} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {acc_ready, out_valid, done, busy, out_val, out_idx, class_idx});
        end
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({acc_ready, out_valid, done, busy, out_val, out_idx, class_idx} !== '0) begin
                failures++;
                $display("FAIL idle_outputs cycle=%0d got=%h exp=0", c,
                         {acc_ready, out_valid, done, busy, out_val, out_idx, class_idx});
            end
        end
        acc_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] bb[N_OUT] = '{8'b10000011, 8'b10101110, 8'b00100011, 8'b00000010,
                                 8'b00010101, 8'b00000011, 8'b10011111, 8'b11000110,
                                 8'b01010110, 8'b00000111};
        int accs[N_OUT] = '{100, 200, 50, 0, 0, 0, 0, 0, 0, 0};
        int expv[N_OUT] = '{97, 154, 85, 2, 21, 3, -31, -70, 86, 7};
        logic [8*N_OUT-1:0] bus;
        int  b_obs, b_done, b_al;
        bit  ok1, ok2;
        for (int k = 0; k < N_OUT; k++) bus[8*k +: 8] = bb[k];
        b_obs = n_obs; b_done = n_done; b_al = n_aligned;
        drive_pass(bus, accs, N_OUT, 0, 0, 1'b0, ok1);
        wait_done(b_done, ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            failures++;
            $display("FAIL basic_timeout accept_ok=%0d done_ok=%0d exp=1/1", ok1, ok2);
        end
        for (int i = 0; i < N_OUT; i++) begin
            checks++;
            if (int'(obs_val[(b_obs + i) % 256]) !== expv[i] || obs_idx[(b_obs + i) % 256] !== i) begin
                failures++;
                $display("FAIL basic_logit[%0d] got=%0d idx=%0d exp=%0d idx=%0d", i,
                         obs_val[(b_obs + i) % 256], obs_idx[(b_obs + i) % 256], expv[i], i);
            end
        end
        checks++;
        if (n_obs - b_obs !== N_OUT || n_done - b_done !== 1 || n_aligned - b_al !== 1) begin
            failures++;
            $display("FAIL basic_strobes got=%0d/%0d/%0d exp=%0d/1/1",
                     n_obs - b_obs, n_done - b_done, n_aligned - b_al, N_OUT);
        end
        checks++;
        if (done_class !== 1 || int'(class_idx) !== 1) begin
            failures++;
            $display("FAIL basic_class got=%0d held=%0d exp=1", done_class, class_idx);
        end
        checks++;
        if (busy !== 1'b0 || acc_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle_after got busy=%0d ready=%0d exp=0/0", busy, acc_ready);
        end
    endtask

    task automatic test_tie();
        int  accs[N_OUT];
        int  b_obs, b_done;
        bit  ok1, ok2;
        for (int i = 0; i < N_OUT; i++) accs[i] = 5;
        b_obs = n_obs; b_done = n_done;
        drive_pass({N_OUT{8'b10000000}}, accs, N_OUT, 0, 0, 1'b0, ok1);
        wait_done(b_done, ok2);
        checks++;
        if (!(ok1 && ok2) || n_obs - b_obs !== N_OUT) begin
            failures++;
            $display("FAIL tie_handshake got strobes=%0d ok=%0d%0d exp=%0d 11",
                     n_obs - b_obs, ok1, ok2, N_OUT);
        end
        for (int i = 0; i < N_OUT; i++) begin
            checks++;
            if (int'(obs_val[(b_obs + i) % 256]) !== 5) begin
                failures++;
                $display("FAIL tie_logit[%0d] got=%0d exp=5", i, obs_val[(b_obs + i) % 256]);
            end
        end
        checks++;
        if (done_class !== 0) begin
            failures++;
            $display("FAIL tie_class got=%0d exp=0", done_class);
        end
    endtask

    task automatic test_overflow();
        int  accs[N_OUT];
        logic [8*N_OUT-1:0] bus;
        int  b_obs, b_done, exp0;
        bit  ok1, ok2;
`ifdef BO_SAT_EN
        exp0 = 32767;
`else
        exp0 = -32749;
`endif
        bus = '0;
        bus[7:0] = 8'b00100011;
        accs[0] = 32'sh7FF0;
        for (int i = 1; i < N_OUT; i++) accs[i] = -32768;
        b_obs = n_obs; b_done = n_done;
        drive_pass(bus, accs, N_OUT, 0, 0, 1'b0, ok1);
        wait_done(b_done, ok2);
        checks++;
        if (!(ok1 && ok2) || int'(obs_val[b_obs % 256]) !== exp0) begin
            failures++;
            $display("FAIL overflow_logit0 got=%0d exp=%0d ok=%0d%0d",
                     obs_val[b_obs % 256], exp0, ok1, ok2);
        end
        checks++;
        if (int'(obs_val[(b_obs + 5) % 256]) !== -32768) begin
            failures++;
            $display("FAIL overflow_logit5 got=%0d exp=-32768", obs_val[(b_obs + 5) % 256]);
        end
        checks++;
        if (done_class !== 0) begin
            failures++;
            $display("FAIL overflow_class got=%0d exp=0", done_class);
        end
    endtask

    task automatic test_stalls();
        int  accs[N_OUT];
        int  expv[N_OUT];
        logic [8*N_OUT-1:0] bus;
        int  b_obs, b_done;
        bit  ok1, ok2;
        bus = rand_bias();
        for (int i = 0; i < N_OUT; i++) begin
            accs[i] = rand_acc();
            expv[i] = model_logit(bus[8*i +: 8], accs[i]);
        end
        b_obs = n_obs; b_done = n_done;
        drive_pass(bus, accs, N_OUT, 1, 1, 1'b1, ok1);
        wait_done(b_done, ok2);
        checks++;
        if (!(ok1 && ok2) || n_obs - b_obs !== N_OUT || n_done - b_done !== 1) begin
            failures++;
            $display("FAIL stall_counts got strobes=%0d dones=%0d exp=%0d/1",
                     n_obs - b_obs, n_done - b_done, N_OUT);
        end
        for (int i = 0; i < N_OUT; i++) begin
            checks++;
            if (int'(obs_val[(b_obs + i) % 256]) !== expv[i] || obs_idx[(b_obs + i) % 256] !== i) begin
                failures++;
                $display("FAIL stall_logit[%0d] got=%0d exp=%0d", i,
                         obs_val[(b_obs + i) % 256], expv[i]);
            end
        end
        checks++;
        if (done_class !== model_argmax(expv)) begin
            failures++;
            $display("FAIL stall_class got=%0d exp=%0d", done_class, model_argmax(expv));
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_restart got busy=%0d exp=0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int  accs[N_OUT];
        int  expv[N_OUT];
        logic [8*N_OUT-1:0] bus;
        int  b_obs, b_done;
        bit  ok1, ok2;
        bus = rand_bias();
        for (int i = 0; i < N_OUT; i++) accs[i] = rand_acc();
        b_done = n_done;
        drive_pass(bus, accs, 4, 0, 0, 1'b0, ok1);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({acc_ready, out_valid, done, busy, out_val, out_idx, class_idx} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h exp=0",
                     {acc_ready, out_valid, done, busy, out_val, out_idx, class_idx});
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        checks++;
        if (n_done !== b_done || !ok1) begin
            failures++;
            $display("FAIL midreset_no_done got dones=%0d exp=%0d", n_done - b_done, 0);
        end
        for (int i = 0; i < N_OUT; i++) expv[i] = model_logit(bus[8*i +: 8], accs[i]);
        b_obs = n_obs; b_done = n_done;
        drive_pass(bus, accs, N_OUT, 0, 2, 1'b0, ok1);
        wait_done(b_done, ok2);
        checks++;
        if (!(ok1 && ok2) || n_obs - b_obs !== N_OUT || done_class !== model_argmax(expv)) begin
            failures++;
            $display("FAIL midreset_repass got strobes=%0d class=%0d exp=%0d/%0d",
                     n_obs - b_obs, done_class, N_OUT, model_argmax(expv));
        end
        for (int i = 0; i < N_OUT; i++) begin
            checks++;
            if (int'(obs_val[(b_obs + i) % 256]) !== expv[i]) begin
                failures++;
                $display("FAIL midreset_logit[%0d] got=%0d exp=%0d", i,
                         obs_val[(b_obs + i) % 256], expv[i]);
            end
        end
    endtask

    task automatic test_random();
        int  accs[N_OUT];
        int  expv[N_OUT];
        logic [8*N_OUT-1:0] bus;
        int  b_obs, b_done;
        bit  ok1, ok2;
        for (int p = 0; p < 20; p++) begin
            bus = rand_bias();
            for (int i = 0; i < N_OUT; i++) begin
                accs[i] = rand_acc();
                expv[i] = model_logit(bus[8*i +: 8], accs[i]);
            end
            b_obs = n_obs; b_done = n_done;
            drive_pass(bus, accs, N_OUT, 0, (p % 3), 1'b0, ok1);
            wait_done(b_done, ok2);
            checks++;
            if (!(ok1 && ok2) || n_obs - b_obs !== N_OUT || n_done - b_done !== 1) begin
                failures++;
                $display("FAIL rand%0d_counts got strobes=%0d dones=%0d exp=%0d/1",
                         p, n_obs - b_obs, n_done - b_done, N_OUT);
            end
            for (int i = 0; i < N_OUT; i++) begin
                checks++;
                if (int'(obs_val[(b_obs + i) % 256]) !== expv[i] || obs_idx[(b_obs + i) % 256] !== i) begin
                    failures++;
                    $display("FAIL rand%0d_logit[%0d] got=%0d idx=%0d exp=%0d", p, i,
                             obs_val[(b_obs + i) % 256], obs_idx[(b_obs + i) % 256], expv[i]);
                end
            end
            checks++;
            if (done_class !== model_argmax(expv)) begin
                failures++;
                $display("FAIL rand%0d_class got=%0d exp=%0d", p, done_class, model_argmax(expv));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_overflow();
        test_stalls();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
